// File: rtl/rc5_key_expand_if.sv
// Bus between the RC5 key schedule and the decipher core.
// Carries the start/key load, the two S-table read ports and the ready flag.
interface rc5_key_expand_if #(
    parameter int W = 32,
    parameter int R = 12,
    parameter int B = 16
);
    localparam int T  = 2 * (R + 1);
    localparam int AW = $clog2(T);

    logic            start;
    logic [8*B-1:0]  key;
    logic [AW-1:0]   s_address1;
    logic [AW-1:0]   s_address2;
    logic [W-1:0]    s_sub_i1;
    logic [W-1:0]    s_sub_i2;
    logic            ready;

    modport master (
        output start, key, s_address1, s_address2,
        input  s_sub_i1, s_sub_i2, ready
    );

    modport slave (
        input  start, key, s_address1, s_address2,
        output s_sub_i1, s_sub_i2, ready
    );
endinterface

// File: rtl/rc5_key_expand.sv
// RC5-W/R/B key schedule: expands the key into S[0..T-1] and serves two registered read ports.
// Optional macro RC5_KEY_CLEAR_EN adds a WIPE state that zeroes L[] and the latched key after MIX.
module rc5_key_expand #(
    parameter int             W       = 32,
    parameter int             R       = 12,
    parameter int             B       = 16,
    parameter logic [W-1:0]   P_CONST = 'hB7E15163,
    parameter logic [W-1:0]   Q_CONST = 'h9E3779B9
) (
    input  logic clk,
    input  logic rst,
    rc5_key_expand_if.slave bus
);
    localparam int T     = 2 * (R + 1);
    localparam int U     = W / 8;
    localparam int C     = (B == 0) ? 1 : (B + U - 1) / U;
    localparam int MAXTC = (T > C) ? T : C;
    localparam int M     = 3 * MAXTC;
    localparam int AW    = $clog2(T);
    localparam int JW    = (C > 1) ? $clog2(C) : 1;
    localparam int LW    = $clog2(W);
    localparam int CW    = $clog2(M + 1);
    localparam int KPW   = 8 * U * C;

    typedef enum logic [2:0] {
        IDLE, LOAD_L, INIT_S, MIX,
`ifdef RC5_KEY_CLEAR_EN
        WIPE,
`endif
        DONE
    } state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    s_tab [T];
    logic [W-1:0]    l_tab [C];
    logic [8*B-1:0]  key_reg;
    logic [KPW-1:0]  key_pad;
    logic [W-1:0]    a_reg, b_reg;
    logic [AW-1:0]   i;
    logic [JW-1:0]   j;
    logic [CW-1:0]   cnt;

    logic            last_i, last_j, last_mix;
    logic [W-1:0]    a_new, b_new, sum_ab;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LW-1:0] n);
        logic [2*W-1:0] t;
        t = {x, x} << n;
        return t[2*W-1:W];
    endfunction

    // Bytes past the key length read as zero when the last L word is partial.
    assign key_pad  = KPW'(key_reg);
    assign last_i   = (i == AW'(T - 1));
    assign last_j   = (j == JW'(C - 1));
    assign last_mix = (cnt == CW'(M - 1));

    always_comb begin
        a_new  = rotl(s_tab[i] + a_reg + b_reg, LW'(3));
        sum_ab = a_new + b_reg;
        b_new  = rotl(l_tab[j] + sum_ab, sum_ab[LW-1:0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (bus.start) state_nxt = LOAD_L;
            LOAD_L:     if (last_j)    state_nxt = INIT_S;
            INIT_S:     if (last_i)    state_nxt = MIX;
`ifdef RC5_KEY_CLEAR_EN
            MIX:        if (last_mix)  state_nxt = WIPE;
            WIPE:                      state_nxt = DONE;
`else
            MIX:        if (last_mix)  state_nxt = DONE;
`endif
            default:                   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < T; n++) s_tab[n] <= '0;
            for (int n = 0; n < C; n++) l_tab[n] <= '0;
            key_reg      <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            i            <= '0;
            j            <= '0;
            cnt          <= '0;
            bus.ready    <= 1'b0;
            bus.s_sub_i1 <= '0;
            bus.s_sub_i2 <= '0;
        end else begin
            // Ready tracks residency in DONE, so a restart from DONE drops it on the same edge.
            bus.ready    <= (state_nxt == DONE);
            bus.s_sub_i1 <= (int'(bus.s_address1) < T) ? s_tab[bus.s_address1] : '0;
            bus.s_sub_i2 <= (int'(bus.s_address2) < T) ? s_tab[bus.s_address2] : '0;

            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        key_reg <= bus.key;
                        i       <= '0;
                        j       <= '0;
                        cnt     <= '0;
                    end
                end
                LOAD_L: begin
                    l_tab[j] <= key_pad[W*int'(j) +: W];
                    j        <= last_j ? '0 : j + 1'b1;
                end
                INIT_S: begin
                    // a_reg carries S[i-1] here, then is cleared for the mix phase.
                    s_tab[i] <= (i == '0) ? P_CONST : a_reg + Q_CONST;
                    if (last_i) begin
                        a_reg <= '0;
                        b_reg <= '0;
                        i     <= '0;
                    end else begin
                        a_reg <= (i == '0) ? P_CONST : a_reg + Q_CONST;
                        i     <= i + 1'b1;
                    end
                end
                MIX: begin
                    s_tab[i] <= a_new;
                    l_tab[j] <= b_new;
                    a_reg    <= a_new;
                    b_reg    <= b_new;
                    i        <= last_i ? '0 : i + 1'b1;
                    j        <= last_j ? '0 : j + 1'b1;
                    cnt      <= cnt + 1'b1;
                end
`ifdef RC5_KEY_CLEAR_EN
                WIPE: begin
                    for (int n = 0; n < C; n++) l_tab[n] <= '0;
                    key_reg <= '0;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rc5_key_expand.sv
// Scoreboard bench for rc5_key_expand: reads are queued with expectations, a monitor checks them.
// Covers reset state, latency, restart from DONE, ignored mid-run starts, reset abort and read boundaries.
module tb_rc5_key_expand;
    localparam int T = 26;
`ifdef RC5_KEY_CLEAR_EN
    localparam int N = 109;
`else
    localparam int N = 108;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rc5_key_expand_if #(.W(32), .R(12), .B(16)) bus();
    rc5_key_expand dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        string       name;
        int          a1;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        er;
        bit          chkd;
        bit          cap;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_s   [T];
    logic [31:0] dut_s [T];
    logic        rd_req = 1'b0;
    logic        rd_vld = 1'b0;

    always @(posedge clk) rd_vld <= rd_req;

    always @(negedge clk) begin
        if (rd_vld) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL orphan_read: data with no queued expectation");
            end else begin
                mon_e = q.pop_front();
                if (bus.ready !== mon_e.er ||
                    (mon_e.chkd && (bus.s_sub_i1 !== mon_e.e1 || bus.s_sub_i2 !== mon_e.e2))) begin
                    n_bad++;
                    $display("FAIL %s: got s1=%h s2=%h rdy=%b need s1=%h s2=%h rdy=%b (data checked=%0d)",
                             mon_e.name, bus.s_sub_i1, bus.s_sub_i2, bus.ready,
                             mon_e.e1, mon_e.e2, mon_e.er, mon_e.chkd);
                end
                if (mon_e.cap && mon_e.a1 >= 0 && mon_e.a1 < T - 1) begin
                    dut_s[mon_e.a1]     = bus.s_sub_i1;
                    dut_s[mon_e.a1 + 1] = bus.s_sub_i2;
                end
            end
        end
    end

    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [31:0] n);
        logic [4:0] s;
        s = n[4:0];
        return (s == 0) ? x : ((x << s) | (x >> (6'd32 - {1'b0, s})));
    endfunction

    function automatic logic [31:0] rotr32(input logic [31:0] x, input logic [31:0] n);
        logic [4:0] s;
        s = n[4:0];
        return (s == 0) ? x : ((x >> s) | (x << (6'd32 - {1'b0, s})));
    endfunction

    // Reference RC5-32/12/16 key schedule.
    task automatic model_expand(input logic [127:0] k);
        logic [31:0] l [4];
        logic [31:0] a, b;
        int ii, jj;
        for (int n = 0; n < 4; n++) l[n] = k[32*n +: 32];
        m_s[0] = 32'hB7E15163;
        for (int n = 1; n < T; n++) m_s[n] = m_s[n-1] + 32'h9E3779B9;
        a = 0; b = 0; ii = 0; jj = 0;
        for (int n = 0; n < 3 * T; n++) begin
            a = rotl32(m_s[ii] + a + b, 32'd3);
            m_s[ii] = a;
            b = rotl32(l[jj] + a + b, a + b);
            l[jj] = b;
            ii = (ii + 1) % T;
            jj = (jj + 1) % 4;
        end
    endtask

    function automatic logic [31:0] mv(input int a);
        return (a < T) ? m_s[a] : 32'h0;
    endfunction

    task automatic issue(input int a1, input int a2, input logic [31:0] e1, input logic [31:0] e2,
                         input logic er, input bit chkd, input bit cap, input string name);
        exp_t e;
        bus.s_address1 = 5'(a1);
        bus.s_address2 = 5'(a2);
        e.name = name; e.a1 = a1; e.e1 = e1; e.e2 = e2; e.er = er; e.chkd = chkd; e.cap = cap;
        q.push_back(e);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    // Ends just after the start edge (edge 0); ready must read 0 after that edge.
    task automatic start_exp(input logic [127:0] k, input string name);
        bus.key   = k;
        bus.start = 1'b1;
        model_expand(k);
        issue(0, 1, 0, 0, 1'b0, 1'b0, 1'b0, name);
        bus.start = 1'b0;
    endtask

    // Called after edge `done_edges`; checks ready low after edge N-1 and high after edge N.
    task automatic check_latency(input int done_edges, input string name);
        repeat (N - 2 - done_edges) @(negedge clk);
        issue(0, 1, 0, 0, 1'b0, 1'b0, 1'b0, {name, "_pre"});
        issue(0, 1, mv(0), mv(1), 1'b1, 1'b1, 1'b0, {name, "_rise"});
    endtask

    task automatic read_table(input string name);
        for (int k = 0; k < T / 2; k++)
            issue(2*k, 2*k + 1, mv(2*k), mv(2*k + 1), 1'b1, 1'b1, 1'b1, name);
        repeat (2) @(negedge clk);
    endtask

    task automatic decipher_check(input bit expect_zero, input string name);
        logic [31:0] a, b;
        a = 32'hEEDBA521;
        b = 32'h6D8F4B15;
        for (int r = 12; r >= 1; r--) begin
            b = rotr32(b - dut_s[2*r + 1], a) ^ a;
            a = rotr32(a - dut_s[2*r], b) ^ b;
        end
        b = b - dut_s[1];
        a = a - dut_s[0];
        n_cmp++;
        if (expect_zero ? (a != 0 || b != 0) : (a == 0 && b == 0)) begin
            n_bad++;
            $display("FAIL %s: decipher gave A=%h B=%h, zero result required=%0d",
                     name, a, b, expect_zero);
        end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.key        = '0;
        bus.s_address1 = '0;
        bus.s_address2 = '0;
        for (int n = 0; n < T; n++) dut_s[n] = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue(0, 25, 0, 0, 1'b0, 1'b1, 1'b0, "reset_state");

        // Zero key: latency, full table, known cipher vector, read-port boundaries.
        start_exp(128'h0, "start_key0");
        check_latency(0, "lat_key0");
        read_table("table_key0");
        decipher_check(1'b1, "decipher_key0");
        issue(24, 24, mv(24), mv(24), 1'b1, 1'b1, 1'b0, "same_addr24");
        issue(26, 26, 0, 0, 1'b1, 1'b1, 1'b0, "addr26_zero");
        issue(31, 0, 0, mv(0), 1'b1, 1'b1, 1'b0, "addr31_zero");

        // Start held for 50 cycles mid-expansion must not disturb anything.
        start_exp(128'h0, "start_hold");
        repeat (20) @(negedge clk);
        bus.start = 1'b1;
        repeat (50) @(negedge clk);
        bus.start = 1'b0;
        check_latency(70, "lat_hold");
        read_table("table_hold");
        decipher_check(1'b1, "decipher_hold");

        // Restart from DONE with a different key, then return to the zero key.
        start_exp(128'h0102030405060708090A0B0C0D0E0F10, "drop_on_restart");
        check_latency(0, "lat_key1");
        read_table("table_key1");
        decipher_check(1'b0, "decipher_key1_nonzero");
        start_exp(128'h0, "restart_key0");
        check_latency(0, "lat_reload");
        read_table("table_reload");
        decipher_check(1'b1, "decipher_reload");

        // Reset at cycle 60 aborts the run and clears the table.
        start_exp(128'hFFEEDDCCBBAA99887766554433221100, "start_abort");
        repeat (59) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < T / 2; k++)
            issue(2*k, 2*k + 1, 0, 0, 1'b0, 1'b1, 1'b0, "after_reset");
        repeat (10) @(negedge clk);
        issue(0, 1, 0, 0, 1'b0, 1'b1, 1'b0, "idle_after_reset");
        start_exp(128'hFFEEDDCCBBAA99887766554433221100, "start_after_reset");
        check_latency(0, "lat_after_reset");
        read_table("table_after_reset");

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL queue_drain: %0d expectations left, 0 required", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
